// File: rtl/piece_spawner_if.sv
// Bus between the piece spawner and its environment.
// It carries the spawn request, the grid memory port and the spawn status.
interface piece_spawner_if;
    logic       start;
    logic [7:0] src_addr_1;
    logic [7:0] src_addr_2;
    logic [7:0] src_addr_3;
    logic [7:0] src_addr_4;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       game_over;
    logic [7:0] piece_addr_1;
    logic [7:0] piece_addr_2;
    logic [7:0] piece_addr_3;
    logic [7:0] piece_addr_4;

    modport master (
        output start, src_addr_1, src_addr_2, src_addr_3, src_addr_4, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, busy, done, game_over,
        input  piece_addr_1, piece_addr_2, piece_addr_3, piece_addr_4
    );

    modport slave (
        input  start, src_addr_1, src_addr_2, src_addr_3, src_addr_4, mem_rdata,
        output mem_addr, mem_we, mem_wdata, busy, done, game_over,
        output piece_addr_1, piece_addr_2, piece_addr_3, piece_addr_4
    );
endinterface

// File: rtl/piece_spawner.sv
// Moves the staged preview piece into the playfield spawn position.
// If a destination cell is occupied, the block flags game over instead.
module piece_spawner #(
    parameter logic [7:0] NEXT_PIECE_BASE_ADDR = 8'd232,
    parameter logic [7:0] PLAYFIELD_WIDTH      = 8'd10,
    parameter logic [7:0] SPAWN_COL            = 8'd4
) (
    input  logic           clk,
    input  logic           rst,
    piece_spawner_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_COLOR = 3'd1,
        S_CHECK    = 3'd2,
        S_WRITE    = 3'd3,
        S_DONE     = 3'd4,
        S_OVER     = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] src_q [4];
    logic [7:0] dst_q [4];
    logic [7:0] piece_addr_q [4];
    logic [7:0] colour_q;
    logic       coll_q;
    logic       invalid_q;
    logic [7:0] src_in_s [4];
    logic [7:0] mem_addr_s;
    logic       mem_we_s;
    logic [7:0] mem_wdata_s;
    logic       busy_s;
    logic       done_s;
    logic       game_over_s;

    function automatic logic [7:0] dest_of(input logic [7:0] src);
        logic [7:0] k;
        k = src - NEXT_PIECE_BASE_ADDR;
        return ((k / 8'd3) * PLAYFIELD_WIDTH) + (k % 8'd3) + SPAWN_COL;
    endfunction

    function automatic logic outside_preview(input logic [7:0] src);
        return (src < NEXT_PIECE_BASE_ADDR) || (src > (NEXT_PIECE_BASE_ADDR + 8'd11));
    endfunction

    assign src_in_s[0] = bus.src_addr_1;
    assign src_in_s[1] = bus.src_addr_2;
    assign src_in_s[2] = bus.src_addr_3;
    assign src_in_s[3] = bus.src_addr_4;

    // State and phase counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch, colour/collision capture and spawned-piece addresses
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q        <= '{default: 8'd0};
            dst_q        <= '{default: 8'd0};
            piece_addr_q <= '{default: 8'd0};
            colour_q     <= 8'd0;
            coll_q       <= 1'b0;
            invalid_q    <= 1'b0;
        end else if (state_q == S_IDLE && bus.start) begin
            for (int i = 0; i < 4; i++) begin
                src_q[i] <= src_in_s[i];
                dst_q[i] <= dest_of(src_in_s[i]);
            end
            invalid_q <= outside_preview(src_in_s[0]) | outside_preview(src_in_s[1]) |
                         outside_preview(src_in_s[2]) | outside_preview(src_in_s[3]);
            coll_q    <= 1'b0;
        end else if (state_q == S_CHECK) begin
            // Read data lags the address by one cycle: c=0 sees the colour cell.
            if (cnt_q == 3'd0) begin
                colour_q <= bus.mem_rdata;
            end else begin
                coll_q <= coll_q | (bus.mem_rdata != 8'd0);
            end
        end else if (state_q == S_WRITE && cnt_q == 3'd7) begin
            piece_addr_q <= dst_q;
        end
    end

    // Next-state and counter decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RD_COLOR;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_COLOR: begin
                state_d = S_CHECK;
                cnt_d   = 3'd0;
            end
            S_CHECK: begin
                if (cnt_q == 3'd4) begin
                    cnt_d = 3'd0;
                    // Last occupancy read is still on mem_rdata, not yet in coll_q.
                    if (invalid_q || colour_q == 8'd0) begin
                        state_d = S_DONE;
                    end else if (coll_q || bus.mem_rdata != 8'd0) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_WRITE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WRITE: begin
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_OVER:  state_d = S_OVER;
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Memory port and status decode from state/counter
    always_comb begin
        mem_addr_s  = 8'd0;
        mem_we_s    = 1'b0;
        mem_wdata_s = 8'd0;
        busy_s      = 1'b1;
        done_s      = 1'b0;
        game_over_s = 1'b0;
        case (state_q)
            S_IDLE:     busy_s = 1'b0;
            S_RD_COLOR: mem_addr_s = src_q[0];
            S_CHECK: begin
                if (cnt_q < 3'd4) begin
                    mem_addr_s = dst_q[cnt_q[1:0]];
                end else begin
                    mem_addr_s = 8'd0;
                end
            end
            S_WRITE: begin
                mem_we_s = 1'b1;
                // First four phases paint the piece, last four clear the preview.
                if (cnt_q < 3'd4) begin
                    mem_addr_s  = dst_q[cnt_q[1:0]];
                    mem_wdata_s = colour_q;
                end else begin
                    mem_addr_s  = src_q[cnt_q[1:0]];
                    mem_wdata_s = 8'd0;
                end
            end
            S_DONE:     done_s = 1'b1;
            S_OVER: begin
                busy_s      = 1'b0;
                game_over_s = 1'b1;
            end
            default:    busy_s = 1'b0;
        endcase
    end

    assign bus.mem_addr     = mem_addr_s;
    assign bus.mem_we       = mem_we_s & ~rst;
    assign bus.mem_wdata    = mem_wdata_s;
    assign bus.busy         = busy_s;
    assign bus.done         = done_s;
    assign bus.game_over    = game_over_s;
    assign bus.piece_addr_1 = piece_addr_q[0];
    assign bus.piece_addr_2 = piece_addr_q[1];
    assign bus.piece_addr_3 = piece_addr_q[2];
    assign bus.piece_addr_4 = piece_addr_q[3];

endmodule
